// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter and sequencer between two requesters
// (r0 instruction side, r1 data side) and the 2048 x 256-bit main memory.
// One transaction is in flight at a time: accept, issue a single-cycle memory
// strobe, capture registered read data, then pulse the requester's response.
module mem_req_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 256
) (
    input  logic               clk,
    input  logic               reset,

    // requester 0 (instruction side)
    input  logic               r0_valid,
    input  logic [1:0]         r0_op,
    input  logic [ADDR_W-1:0]  r0_addr,
    input  logic [WORD_W-1:0]  r0_wword,
    input  logic [BLOCK_W-1:0] r0_wblock,
    output logic               r0_ready,
    output logic               r0_resp_valid,
    output logic [WORD_W-1:0]  r0_rword,
    output logic [BLOCK_W-1:0] r0_rblock,

    // requester 1 (data side)
    input  logic               r1_valid,
    input  logic [1:0]         r1_op,
    input  logic [ADDR_W-1:0]  r1_addr,
    input  logic [WORD_W-1:0]  r1_wword,
    input  logic [BLOCK_W-1:0] r1_wblock,
    output logic               r1_ready,
    output logic               r1_resp_valid,
    output logic [WORD_W-1:0]  r1_rword,
    output logic [BLOCK_W-1:0] r1_rblock,

    // main memory
    output logic               mem_write_en_word,
    output logic               mem_write_en_block,
    output logic               mem_read_word_en,
    output logic               mem_read_block_en,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_write_word,
    output logic [BLOCK_W-1:0] mem_write_block,
    input  logic [WORD_W-1:0]  mem_read_word,
    input  logic [BLOCK_W-1:0] mem_read_block
);

    // Operation encoding; bit 0 set means write, bit 1 set means block access.
    localparam logic [1:0] OP_RD_WORD  = 2'b00;
    localparam logic [1:0] OP_WR_WORD  = 2'b01;
    localparam logic [1:0] OP_RD_BLOCK = 2'b10;
    localparam logic [1:0] OP_WR_BLOCK = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Requester currently (or most recently) granted: 0 = r0, 1 = r1.
    // Resets to 1 so r0 wins the first contention.
    logic grant_q;

    // Latched request, held for the whole transaction.
    logic [1:0]         req_op;
    logic [ADDR_W-1:0]  req_addr;
    logic [WORD_W-1:0]  req_wword;
    logic [BLOCK_W-1:0] req_wblock;

    // Arbitration and acceptance signals.
    logic               any_valid;
    logic               pick;
    logic               accept;
    logic               in_resp;

    // Fields of the requester chosen this cycle.
    logic [1:0]         sel_op;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WORD_W-1:0]  sel_wword;
    logic [BLOCK_W-1:0] sel_wblock;

    // Round-robin pick: a lone valid wins, on contention the requester not
    // granted last time wins.
    always_comb begin
        any_valid = r0_valid | r1_valid;
        if (r0_valid && r1_valid) begin
            pick = ~grant_q;
        end else begin
            pick = r1_valid;
        end
    end

    // Route the picked requester's fields towards the request latch.
    always_comb begin
        if (pick) begin
            sel_op     = r1_op;
            sel_addr   = r1_addr;
            sel_wword  = r1_wword;
            sel_wblock = r1_wblock;
        end else begin
            sel_op     = r0_op;
            sel_addr   = r0_addr;
            sel_wword  = r0_wword;
            sel_wblock = r0_wblock;
        end
    end

    // Next-state logic; acceptance is suppressed while reset is asserted so a
    // request is never acknowledged without being carried out.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid && !reset) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // writes finish at the strobe edge, reads need the capture cycle
                if (req_op[0]) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and memory-strobe outputs, all decoded from the current state.
    always_comb begin
        in_resp            = (state_q == RESP) && !reset;
        r0_ready           = accept & ~pick;
        r1_ready           = accept &  pick;
        r0_resp_valid      = in_resp & ~grant_q;
        r1_resp_valid      = in_resp &  grant_q;
        mem_read_word_en   = (state_q == ISSUE) && (req_op == OP_RD_WORD);
        mem_write_en_word  = (state_q == ISSUE) && (req_op == OP_WR_WORD);
        mem_read_block_en  = (state_q == ISSUE) && (req_op == OP_RD_BLOCK);
        mem_write_en_block = (state_q == ISSUE) && (req_op == OP_WR_BLOCK);
        mem_addr           = req_addr;
        mem_write_word     = req_wword;
        mem_write_block    = req_wblock;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant register: records who owns the transaction and steers round-robin.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= 1'b1;
        end else if (accept) begin
            grant_q <= pick;
        end
    end

    // Request latch, loaded on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_op     <= OP_RD_WORD;
            req_addr   <= '0;
            req_wword  <= '0;
            req_wblock <= '0;
        end else if (accept) begin
            req_op     <= sel_op;
            req_addr   <= sel_addr;
            req_wword  <= sel_wword;
            req_wblock <= sel_wblock;
        end
    end

    // Read-data capture into the granted requester's response registers; the
    // other requester's registers and the unused width keep their contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_rword  <= '0;
            r0_rblock <= '0;
            r1_rword  <= '0;
            r1_rblock <= '0;
        end else if (state_q == WAIT) begin
            if (req_op == OP_RD_WORD) begin
                if (grant_q) begin
                    r1_rword <= mem_read_word;
                end else begin
                    r0_rword <= mem_read_word;
                end
            end else if (req_op == OP_RD_BLOCK) begin
                if (grant_q) begin
                    r1_rblock <= mem_read_block;
                end else begin
                    r0_rblock <= mem_read_block;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and randomized stimulus for mem_req_arbiter,
// with a behavioural main memory and a transaction-level reference model.
module tb_mem_req_arbiter;

    localparam int ADDR_W  = 16;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 256;

    localparam logic [1:0] RDW = 2'b00;
    localparam logic [1:0] WRW = 2'b01;
    localparam logic [1:0] RDB = 2'b10;
    localparam logic [1:0] WRB = 2'b11;

    logic               clk = 1'b0;
    logic               reset;
    logic               r0_valid, r1_valid;
    logic [1:0]         r0_op, r1_op;
    logic [ADDR_W-1:0]  r0_addr, r1_addr;
    logic [WORD_W-1:0]  r0_wword, r1_wword;
    logic [BLOCK_W-1:0] r0_wblock, r1_wblock;
    logic               r0_ready, r1_ready;
    logic               r0_resp_valid, r1_resp_valid;
    logic [WORD_W-1:0]  r0_rword, r1_rword;
    logic [BLOCK_W-1:0] r0_rblock, r1_rblock;
    logic               mem_write_en_word, mem_write_en_block;
    logic               mem_read_word_en, mem_read_block_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_write_word;
    logic [BLOCK_W-1:0] mem_write_block;
    logic [WORD_W-1:0]  mem_read_word;
    logic [BLOCK_W-1:0] mem_read_block;

    mem_req_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_W(BLOCK_W)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_addr(r0_addr),
        .r0_wword(r0_wword), .r0_wblock(r0_wblock), .r0_ready(r0_ready),
        .r0_resp_valid(r0_resp_valid), .r0_rword(r0_rword), .r0_rblock(r0_rblock),
        .r1_valid(r1_valid), .r1_op(r1_op), .r1_addr(r1_addr),
        .r1_wword(r1_wword), .r1_wblock(r1_wblock), .r1_ready(r1_ready),
        .r1_resp_valid(r1_resp_valid), .r1_rword(r1_rword), .r1_rblock(r1_rblock),
        .mem_write_en_word(mem_write_en_word), .mem_write_en_block(mem_write_en_block),
        .mem_read_word_en(mem_read_word_en), .mem_read_block_en(mem_read_block_en),
        .mem_addr(mem_addr), .mem_write_word(mem_write_word),
        .mem_write_block(mem_write_block), .mem_read_word(mem_read_word),
        .mem_read_block(mem_read_block)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Power-up memory contents: low half 0x1000_bb0w, high half 0x2000_bb0w.
    function automatic logic [31:0] init_word(input int idx);
        int blk;
        blk = idx >> 3;
        return ((blk >= 1024) ? 32'h2000_0000 : 32'h1000_0000)
               | 32'((blk % 1024) << 8) | 32'(idx % 8);
    endfunction

    // Behavioural main memory with registered read outputs.
    logic [31:0] mem_w [16384];
    bit          wr_flag [16384];

    function automatic logic [31:0] phys_rd(input int idx);
        return wr_flag[idx] ? mem_w[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        if (mem_write_en_word) begin
            mem_w[mem_addr[15:2]]   <= mem_write_word;
            wr_flag[mem_addr[15:2]] <= 1'b1;
        end
        if (mem_write_en_block) begin
            for (int w = 0; w < 8; w++) begin
                mem_w[{mem_addr[15:5], 3'(w)}]   <= mem_write_block[w*32 +: 32];
                wr_flag[{mem_addr[15:5], 3'(w)}] <= 1'b1;
            end
        end
        if (mem_read_word_en) begin
            mem_read_word <= phys_rd(int'(mem_addr[15:2]));
        end
        if (mem_read_block_en) begin
            for (int w = 0; w < 8; w++) begin
                mem_read_block[w*32 +: 32] <= phys_rd(int'({mem_addr[15:5], 3'(w)}));
            end
        end
    end

    // Reference model: memory image as seen by accepted transactions.
    logic [31:0] refm [int];

    function automatic logic [31:0] ref_rd(input int idx);
        if (refm.exists(idx)) return refm[idx];
        return init_word(idx);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state: one transaction at a time, described by op and accept cycle.
    bit           mon_en = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    int           m_port, m_acc, m_k, m_lat, m_win;
    logic [1:0]   m_op;
    logic [15:0]  m_addr;
    logic [31:0]  m_wword;
    logic [255:0] m_wblock;
    logic [31:0]  m_eword;
    logic [255:0] m_eblock;
    logic [31:0]  e_rword [2];
    logic [255:0] e_rblock [2];
    logic [1:0]   exp_rdy, exp_rsp;
    logic [3:0]   exp_stb;
    int           acc_port_q [$];
    int           acc_cyc_q [$];

    function automatic logic [3:0] stb_of(input logic [1:0] op);
        case (op)
            RDW:     return 4'b0010;
            WRW:     return 4'b1000;
            RDB:     return 4'b0001;
            default: return 4'b0100;
        endcase
    endfunction

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            exp_rdy = 2'b00;
            exp_rsp = 2'b00;
            exp_stb = 4'b0000;
            m_win   = 0;
            m_k     = 0;
            m_lat   = 0;
            if (!m_busy && !reset && (r0_valid || r1_valid)) begin
                if (r0_valid && r1_valid) m_win = m_last ? 0 : 1;
                else                      m_win = r1_valid ? 1 : 0;
                exp_rdy[m_win] = 1'b1;
            end
            chk("ready", 256'({r1_ready, r0_ready}), 256'(exp_rdy));
            if (m_busy) begin
                m_k   = cyc - m_acc;
                m_lat = m_op[0] ? 2 : 3;
                if (m_k == 1) begin
                    exp_stb = stb_of(m_op);
                    chk("issue_addr", 256'(mem_addr), 256'(m_addr));
                    if (m_op == WRW) chk("issue_wword", 256'(mem_write_word), 256'(m_wword));
                    if (m_op == WRB) chk("issue_wblock", mem_write_block, m_wblock);
                end
                if (m_k == m_lat) begin
                    if (!reset) exp_rsp[m_port] = 1'b1;
                    if (m_op == RDW) e_rword[m_port] = m_eword;
                    if (m_op == RDB) e_rblock[m_port] = m_eblock;
                end
            end
            chk("strobes", 256'({mem_write_en_word, mem_write_en_block, mem_read_word_en, mem_read_block_en}),
                256'(exp_stb));
            chk("resp_valid", 256'({r1_resp_valid, r0_resp_valid}), 256'(exp_rsp));
            chk("r0_rword", 256'(r0_rword), 256'(e_rword[0]));
            chk("r1_rword", 256'(r1_rword), 256'(e_rword[1]));
            chk("r0_rblock", r0_rblock, e_rblock[0]);
            chk("r1_rblock", r1_rblock, e_rblock[1]);
            if (m_busy && m_k >= m_lat) m_busy = 1'b0;
            if (reset) begin
                m_busy      = 1'b0;
                m_last      = 1'b1;
                e_rword[0]  = '0;
                e_rword[1]  = '0;
                e_rblock[0] = '0;
                e_rblock[1] = '0;
            end else if (exp_rdy != 2'b00 && exp_rdy == {r1_ready, r0_ready}) begin
                m_busy   = 1'b1;
                m_port   = m_win;
                m_acc    = cyc;
                m_last   = m_win[0];
                m_op     = m_win == 1 ? r1_op     : r0_op;
                m_addr   = m_win == 1 ? r1_addr   : r0_addr;
                m_wword  = m_win == 1 ? r1_wword  : r0_wword;
                m_wblock = m_win == 1 ? r1_wblock : r0_wblock;
                acc_port_q.push_back(m_win);
                acc_cyc_q.push_back(cyc);
                case (m_op)
                    RDW: m_eword = ref_rd(int'(m_addr[15:2]));
                    WRW: refm[int'(m_addr[15:2])] = m_wword;
                    RDB: for (int w = 0; w < 8; w++)
                             m_eblock[w*32 +: 32] = ref_rd(int'(m_addr[15:5]) * 8 + w);
                    default: for (int w = 0; w < 8; w++)
                             refm[int'(m_addr[15:5]) * 8 + w] = m_wblock[w*32 +: 32];
                endcase
            end
        end
    end

    task automatic set_req(input int p, input logic v, input logic [1:0] op,
                           input logic [15:0] a, input logic [31:0] ww, input logic [255:0] wb);
        if (p == 0) begin
            r0_valid = v; r0_op = op; r0_addr = a; r0_wword = ww; r0_wblock = wb;
        end else begin
            r1_valid = v; r1_op = op; r1_addr = a; r1_wword = ww; r1_wblock = wb;
        end
    endtask

    // Present a request, hold it until ready, then wait (bounded) for the response.
    task automatic issue(input int p, input logic [1:0] op, input logic [15:0] a,
                         input logic [31:0] ww, input logic [255:0] wb);
        int  n;
        bit  got;
        set_req(p, 1'b1, op, a, ww, wb);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            #1;
            if ((p == 0) ? r0_ready : r1_ready) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
        if (!got) begin
            chk("ready_timeout", 256'(1'b0), 256'(1'b1));
            set_req(p, 1'b0, 2'b00, 16'h0, 32'h0, '0);
            return;
        end
        @(negedge clk);
        set_req(p, 1'b0, 2'b00, 16'h0, 32'h0, '0);
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            #1;
            if ((p == 0) ? r0_resp_valid : r1_resp_valid) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
        if (!got) chk("resp_timeout", 256'(1'b0), 256'(1'b1));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_stream(input int p, input int count);
        logic [255:0] wb;
        logic [15:0]  a;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int w = 0; w < 8; w++) wb[w*32 +: 32] = $urandom;
            a = 16'($urandom_range(0, 255)) | ($urandom_range(0, 1) == 1 ? 16'h8000 : 16'h0000);
            issue(p, 2'($urandom_range(0, 3)), a, $urandom, wb);
        end
    endtask

    logic [255:0] exp_blk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 2'b00, 16'h0, 32'h0, '0);
        set_req(1, 1'b0, 2'b00, 16'h0, 32'h0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        e_rword[0] = '0; e_rword[1] = '0; e_rblock[0] = '0; e_rblock[1] = '0;
        mon_en = 1'b1;
        #1;
        chk("rst_addr", 256'(mem_addr), 256'(16'h0));
        chk("rst_wword", 256'(mem_write_word), 256'(32'h0));
        chk("rst_wblock", mem_write_block, 256'h0);
        chk("rst_rword0", 256'(r0_rword), 256'(32'h0));
        chk("rst_rblock1", r1_rblock, 256'h0);

        // word read, then block read from the upper half
        @(negedge clk);
        issue(0, RDW, 16'h0004, 32'h0, '0);
        chk("tp_r0_rword", 256'(r0_rword), 256'(32'h1000_0001));
        issue(1, RDB, 16'h8000, 32'h0, '0);
        for (int w = 0; w < 8; w++) exp_blk[w*32 +: 32] = 32'h2000_0000 + 32'(w);
        chk("tp_r1_rblock", r1_rblock, exp_blk);
        chk("tp_r0_held", 256'(r0_rword), 256'(32'h1000_0001));

        // word write observed by a later block read
        issue(0, WRW, 16'h0008, 32'hDEAD_BEEF, '0);
        issue(1, RDB, 16'h0000, 32'h0, '0);
        for (int w = 0; w < 8; w++) exp_blk[w*32 +: 32] = 32'h1000_0000 + 32'(w);
        exp_blk[2*32 +: 32] = 32'hDEAD_BEEF;
        chk("tp_wr_then_rdb", r1_rblock, exp_blk);

        // block write observed by a later word read
        for (int w = 0; w < 8; w++) exp_blk[w*32 +: 32] = 32'hA5A5_0000 + 32'(w);
        issue(1, WRB, 16'h0020, 32'h0, exp_blk);
        issue(0, RDW, 16'h0034, 32'h0, '0);
        chk("tp_wrb_then_rdw", 256'(r0_rword), 256'(32'hA5A5_0005));

        // continuous contention after reset: r0 first, alternating, 4-cycle spacing
        do_reset(2);
        acc_port_q.delete();
        acc_cyc_q.delete();
        fork
            for (int i = 0; i < 3; i++) issue(0, RDW, 16'(4 * i), 32'h0, '0);
            for (int i = 0; i < 3; i++) issue(1, RDW, 16'h8000 + 16'(4 * i), 32'h0, '0);
        join
        chk("cont_count", 256'(acc_port_q.size()), 256'(6));
        for (int i = 0; i < acc_port_q.size(); i++) begin
            chk("cont_port", 256'(acc_port_q[i]), 256'(i % 2));
            if (i > 0) chk("cont_spacing", 256'(acc_cyc_q[i] - acc_cyc_q[i-1]), 256'(4));
        end

        // reset in WAIT during an r0 block read
        @(negedge clk);
        set_req(0, 1'b1, RDB, 16'h8020, 32'h0, '0);
        #1 chk("rw_ready", 256'(r0_ready), 256'(1'b1));
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 16'h0, 32'h0, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw_no_resp", 256'(r0_resp_valid), 256'(1'b0));
        chk("rw_strobes", 256'({mem_write_en_word, mem_write_en_block, mem_read_word_en, mem_read_block_en}),
            256'(4'b0000));
        chk("rw_r0_rblock", r0_rblock, 256'h0);
        chk("rw_r1_rblock", r1_rblock, 256'h0);
        repeat (3) @(negedge clk);
        issue(0, RDB, 16'h8020, 32'h0, '0);
        for (int w = 0; w < 8; w++) exp_blk[w*32 +: 32] = 32'h2000_0100 + 32'(w);
        chk("rw_after", r0_rblock, exp_blk);
        issue(1, RDW, 16'h0034, 32'h0, '0);
        chk("rw_mem_kept", 256'(r1_rword), 256'(32'hA5A5_0005));

        // randomized traffic from both requesters
        fork
            rand_stream(0, 30);
            rand_stream(1, 30);
        join
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-port request arbiter and sequencer for the 64 KiB block-organised main memory (2048 × 256-bit blocks). Two requesters, r0 = instruction-side and r1 = data-side, issue word read/write and block refill/writeback requests. The block grants one requester at a time in round-robin order, drives the memory's single-cycle enable strobes, captures the registered read data and returns a one-cycle response pulse. It sits between the cache/uncached-access logic and the main memory.

## Interface
- ADDR_W, 16, byte address width
- WORD_W, 32, word data width
- BLOCK_W, 256, block data width (8 words, 32 bytes)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rN_valid  in  1  request pending from requester N (N = 0, 1)
- rN_op  in  2  00 word read, 01 word write, 10 block read, 11 block write
- rN_addr  in  ADDR_W  byte address
- rN_wword  in  WORD_W  word-write data
- rN_wblock  in  BLOCK_W  block-write data
- rN_ready  out  1  request accepted this cycle
- rN_resp_valid  out  1  one-cycle completion pulse (reads and writes)
- rN_rword  out  WORD_W  word-read result, held until next response to N
- rN_rblock  out  BLOCK_W  block-read result, held until next response to N
- mem_write_en_word, mem_write_en_block, mem_read_word_en, mem_read_block_en  out  1  memory strobes
- mem_addr  out  ADDR_W  address to all memory address inputs
- mem_write_word  out  WORD_W  write data
- mem_write_block  out  BLOCK_W  write data
- mem_read_word  in  WORD_W  registered memory word output
- mem_read_block  in  BLOCK_W  registered memory block output

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any rN_valid is high, grant one requester and assert its rN_ready combinationally.
  - Latch op, addr and write data at the edge, record the grant, go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration: a lone valid wins. If both are valid, the requester not granted last wins. The last-grant register resets to 1, so r0 wins the first contention.
- ISSUE: exactly one mem strobe is high, chosen by the latched op.
  - mem_addr and write data are driven from the latches.
  - Writes go to RESP. Reads go to WAIT.
- WAIT: memory output is valid. Capture mem_read_word (word read) or mem_read_block (block read) into the granted requester's rword/rblock register, go to RESP. The other response register is unchanged.
- RESP: the granted requester's rN_resp_valid is high for one cycle, then IDLE.
- The ungranted requester's valid is ignored until the FSM returns to IDLE. Its ready stays low.
- Requester rules:
  - Hold valid and all fields stable until ready.
  - At most one outstanding request per requester; do not re-assert valid before resp_valid.
- Address bits below the access granularity ([1:0] word, [4:0] block) pass through unmodified; memory ignores them. No alignment checking.
- All mem strobes are low in every state except ISSUE.
- rN_ready and rN_resp_valid are never high for both requesters in the same cycle.

## Timing
- Reset values: state IDLE, all strobes 0, mem_addr/write data 0, rN_ready 0, rN_resp_valid 0, rN_rword/rN_rblock 0, last-grant 1.
- Accept in cycle c0.
  - Reads: strobe in c1, capture in c2, resp_valid in c3, IDLE in c4.
  - Writes: strobe in c1, resp_valid in c2, IDLE in c3.
- Read latency from ready to resp_valid is 3 cycles; write latency is 2 cycles.
- Next accept can occur the cycle after RESP: back-to-back reads every 4 cycles, writes every 3 cycles.
- A write completes in memory at the ISSUE edge. A read accepted later observes it.
- Reset in any state: next cycle IDLE, strobes low, no resp_valid for the aborted transaction.
  - A write aborted before ISSUE is not performed. One aborted at the ISSUE edge is performed.
  - Response data registers clear to 0.

## Test plan
- Reset, then r0 word read at 0x0004 → r0_ready in c0, mem_read_word_en only in c1, r0_resp_valid in c3, r0_rword = 0x1000_0001.
- r1 block read at 0x8000 → r1_resp_valid 3 cycles after ready, r1_rblock words[0..7] = 0x2000_0000..0x2000_0007, r0 outputs unchanged.
- r0 word write 0xDEADBEEF at 0x0008 (resp after 2 cycles), then r1 block read at 0x0000 → word2 = 0xDEADBEEF, other words = 0x1000_000w.
- r1 block write of pattern 0xA5A5_0000+w at 0x0020, then r0 word read at 0x0034 → 0xA5A5_0005.
- Both valid continuously with word reads, 6 transactions → grants alternate r0, r1, r0, …, starting with r0. Never two readys or two resp_valids in the same cycle. Spacing is 4 cycles.
- Reset asserted in WAIT during an r0 block read → no r0_resp_valid, all strobes low, rN_rblock = 0, next request served normally.
